// File: rtl/wb_merge.sv
// Writeback merge: pipeline writes take the regfile port first, long-latency results
// wait in a small FIFO, and a pending scoreboard tracks outstanding long-latency dests.
module wb_merge #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5,
    parameter int NUM_REGS      = 32,
    parameter int FIFO_DEPTH    = 4,
    localparam int PTR_W        = $clog2(FIFO_DEPTH),
    localparam int CNT_W        = PTR_W + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pipe_wrt_en,
    input  logic [ADDRESS_WIDTH-1:0] pipe_wrt_dest,
    input  logic [DATA_WIDTH-1:0]    pipe_wrt_data,
    input  logic                     lu_valid,
    output logic                     lu_ready,
    input  logic [ADDRESS_WIDTH-1:0] lu_dest,
    input  logic [DATA_WIDTH-1:0]    lu_data,
    input  logic                     lu_issue,
    input  logic [ADDRESS_WIDTH-1:0] lu_issue_dest,
    output logic                     rg_wrt_en,
    output logic [ADDRESS_WIDTH-1:0] rg_wrt_dest,
    output logic [DATA_WIDTH-1:0]    rg_wrt_data,
    output logic [NUM_REGS-1:0]      pending,
    output logic [CNT_W-1:0]         fifo_count
);

    localparam logic [CNT_W-1:0]         FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDRESS_WIDTH-1:0] ZERO_REG = '0;

    logic [ADDRESS_WIDTH-1:0] buf_dest_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]    buf_data_q [FIFO_DEPTH];

    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic [NUM_REGS-1:0]      pending_q, pending_d;
    logic                     rg_en_q, rg_en_d;
    logic [ADDRESS_WIDTH-1:0] rg_dest_q, rg_dest_d;
    logic [DATA_WIDTH-1:0]    rg_data_q, rg_data_d;

    logic                     lu_accept;
    logic                     push;
    logic                     pop;
    logic                     pipe_sel;
    logic [ADDRESS_WIDTH-1:0] head_dest;
    logic [DATA_WIDTH-1:0]    head_data;

    // Ready depends only on registered occupancy, so a same-cycle pop never frees a slot early.
    assign lu_ready  = !rst && (count_q != FULL_CNT);
    assign lu_accept = lu_valid && lu_ready;
    assign push      = lu_accept && (lu_dest != ZERO_REG);
    assign pipe_sel  = pipe_wrt_en && (pipe_wrt_dest != ZERO_REG);
    assign pop       = !pipe_sel && (count_q != '0);
    assign head_dest = buf_dest_q[rd_ptr_q];
    assign head_data = buf_data_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // A completion and a new issue to the same register in one cycle leave the bit set.
    always_comb begin
        pending_d = pending_q;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (pop && (head_dest == ADDRESS_WIDTH'(i))) begin
                pending_d[i] = 1'b0;
            end
            if (lu_issue && (lu_issue_dest == ADDRESS_WIDTH'(i))) begin
                pending_d[i] = 1'b1;
            end
        end
        pending_d[0] = 1'b0;
    end

    always_comb begin
        rg_en_d   = 1'b0;
        rg_dest_d = rg_dest_q;
        rg_data_d = rg_data_q;
        if (pipe_sel) begin
            rg_en_d   = 1'b1;
            rg_dest_d = pipe_wrt_dest;
            rg_data_d = pipe_wrt_data;
        end else if (pop) begin
            rg_en_d   = 1'b1;
            rg_dest_d = head_dest;
            rg_data_d = head_data;
        end
    end

    // ---- stage boundary: FIFO storage (entries are only ever read after being written) ----
    always_ff @(posedge clk) begin
        if (push) begin
            buf_dest_q[wr_ptr_q] <= lu_dest;
            buf_data_q[wr_ptr_q] <= lu_data;
        end
    end

    // ---- stage boundary: control state and registered regfile write ----
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            pending_q <= '0;
            rg_en_q   <= 1'b0;
            rg_dest_q <= '0;
            rg_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            pending_q <= pending_d;
            rg_en_q   <= rg_en_d;
            rg_dest_q <= rg_dest_d;
            rg_data_q <= rg_data_d;
        end
    end

    assign rg_wrt_en   = rg_en_q;
    assign rg_wrt_dest = rg_dest_q;
    assign rg_wrt_data = rg_data_q;
    assign pending     = pending_q;
    assign fifo_count  = count_q;

endmodule

// File: tb/tb_wb_merge.sv
// Directed bench for wb_merge: inputs change 1ns after posedge, outputs are checked there too.
module tb_wb_merge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pipe_wrt_en = 1'b0;
    logic [4:0]  pipe_wrt_dest = '0;
    logic [31:0] pipe_wrt_data = '0;
    logic        lu_valid = 1'b0;
    logic        lu_ready;
    logic [4:0]  lu_dest = '0;
    logic [31:0] lu_data = '0;
    logic        lu_issue = 1'b0;
    logic [4:0]  lu_issue_dest = '0;
    logic        rg_wrt_en;
    logic [4:0]  rg_wrt_dest;
    logic [31:0] rg_wrt_data;
    logic [31:0] pending;
    logic [2:0]  fifo_count;

    int total = 0;
    int bad = 0;

    wb_merge dut (
        .clk(clk), .rst(rst),
        .pipe_wrt_en(pipe_wrt_en), .pipe_wrt_dest(pipe_wrt_dest), .pipe_wrt_data(pipe_wrt_data),
        .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_dest(lu_dest), .lu_data(lu_data),
        .lu_issue(lu_issue), .lu_issue_dest(lu_issue_dest),
        .rg_wrt_en(rg_wrt_en), .rg_wrt_dest(rg_wrt_dest), .rg_wrt_data(rg_wrt_data),
        .pending(pending), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pipe_wrt_en = 1'b0; pipe_wrt_dest = '0; pipe_wrt_data = '0;
        lu_valid = 1'b0; lu_dest = '0; lu_data = '0;
        lu_issue = 1'b0; lu_issue_dest = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pipe_wrt_en = 1'b1; pipe_wrt_dest = 5'd5; pipe_wrt_data = 32'h1111_2222;
        lu_valid = 1'b1; lu_dest = 5'd6; lu_data = 32'h3333;
        lu_issue = 1'b1; lu_issue_dest = 5'd3;
        tick();
        tick();
        total++; if (rg_wrt_en !== 1'b0) begin bad++; $display("FAIL reset_en got=%b exp=0", rg_wrt_en); end
        total++; if (rg_wrt_dest !== 5'd0) begin bad++; $display("FAIL reset_dest got=%0d exp=0", rg_wrt_dest); end
        total++; if (rg_wrt_data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", rg_wrt_data); end
        total++; if (pending !== 32'h0) begin bad++; $display("FAIL reset_pending got=%h exp=0", pending); end
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
        total++; if (lu_ready !== 1'b0) begin bad++; $display("FAIL reset_ready_in_rst got=%b exp=0", lu_ready); end
        idle_inputs();
        rst = 1'b0;
        #1;
        total++; if (lu_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_after got=%b exp=1", lu_ready); end
    endtask

    task automatic test_pipe_write();
        pipe_wrt_en = 1'b1; pipe_wrt_dest = 5'd5; pipe_wrt_data = 32'hDEAD_BEEF;
        tick();
        total++; if (rg_wrt_en !== 1'b1) begin bad++; $display("FAIL pipe_en got=%b exp=1", rg_wrt_en); end
        total++; if (rg_wrt_dest !== 5'd5) begin bad++; $display("FAIL pipe_dest got=%0d exp=5", rg_wrt_dest); end
        total++; if (rg_wrt_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL pipe_data got=%h exp=deadbeef", rg_wrt_data); end
        idle_inputs();
        tick();
        total++; if (rg_wrt_en !== 1'b0) begin bad++; $display("FAIL pipe_idle_en got=%b exp=0", rg_wrt_en); end
        total++; if (rg_wrt_dest !== 5'd5) begin bad++; $display("FAIL pipe_hold_dest got=%0d exp=5", rg_wrt_dest); end
        total++; if (rg_wrt_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL pipe_hold_data got=%h exp=deadbeef", rg_wrt_data); end
    endtask

    task automatic test_lu_latency();
        lu_issue = 1'b1; lu_issue_dest = 5'd7;
        tick();
        total++; if (pending !== 32'h0000_0080) begin bad++; $display("FAIL lat_pending_set got=%h exp=00000080", pending); end
        idle_inputs();
        tick();
        tick();
        lu_valid = 1'b1; lu_dest = 5'd7; lu_data = 32'h1234;
        total++; if (lu_ready !== 1'b1) begin bad++; $display("FAIL lat_ready got=%b exp=1", lu_ready); end
        tick();
        idle_inputs();
        total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL lat_count got=%0d exp=1", fifo_count); end
        total++; if (rg_wrt_en !== 1'b0) begin bad++; $display("FAIL lat_no_bypass got=%b exp=0", rg_wrt_en); end
        total++; if (pending !== 32'h0000_0080) begin bad++; $display("FAIL lat_pending_hold got=%h exp=00000080", pending); end
        tick();
        total++; if (rg_wrt_en !== 1'b1) begin bad++; $display("FAIL lat_en got=%b exp=1", rg_wrt_en); end
        total++; if (rg_wrt_dest !== 5'd7) begin bad++; $display("FAIL lat_dest got=%0d exp=7", rg_wrt_dest); end
        total++; if (rg_wrt_data !== 32'h1234) begin bad++; $display("FAIL lat_data got=%h exp=1234", rg_wrt_data); end
        total++; if (pending !== 32'h0) begin bad++; $display("FAIL lat_pending_clr got=%h exp=0", pending); end
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL lat_count_empty got=%0d exp=0", fifo_count); end
        tick();
    endtask

    task automatic test_full();
        logic [2:0] exp_cnt [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4};
        logic       exp_rdy [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int k = 0; k < 6; k++) begin
            pipe_wrt_en = 1'b1; pipe_wrt_dest = 5'd3; pipe_wrt_data = 32'hA0 + k;
            lu_valid = 1'b1; lu_dest = 5'(10 + k); lu_data = 32'h100 + k;
            tick();
            total++; if (rg_wrt_en !== 1'b1 || rg_wrt_dest !== 5'd3 || rg_wrt_data !== 32'hA0 + k)
                begin bad++; $display("FAIL full_pipe[%0d] got=%b/%0d/%h exp=1/3/%h", k, rg_wrt_en, rg_wrt_dest, rg_wrt_data, 32'hA0 + k); end
            total++; if (fifo_count !== exp_cnt[k]) begin bad++; $display("FAIL full_count[%0d] got=%0d exp=%0d", k, fifo_count, exp_cnt[k]); end
            total++; if (lu_ready !== exp_rdy[k]) begin bad++; $display("FAIL full_ready[%0d] got=%b exp=%b", k, lu_ready, exp_rdy[k]); end
        end
        idle_inputs();
        for (int k = 0; k < 4; k++) begin
            tick();
            total++; if (rg_wrt_en !== 1'b1 || rg_wrt_dest !== 5'(10 + k) || rg_wrt_data !== 32'h100 + k)
                begin bad++; $display("FAIL drain[%0d] got=%b/%0d/%h exp=1/%0d/%h", k, rg_wrt_en, rg_wrt_dest, rg_wrt_data, 10 + k, 32'h100 + k); end
            total++; if (fifo_count !== 3'(3 - k)) begin bad++; $display("FAIL drain_count[%0d] got=%0d exp=%0d", k, fifo_count, 3 - k); end
            total++; if (lu_ready !== 1'b1) begin bad++; $display("FAIL drain_ready[%0d] got=%b exp=1", k, lu_ready); end
        end
        tick();
        total++; if (rg_wrt_en !== 1'b0) begin bad++; $display("FAIL drain_done got=%b exp=0", rg_wrt_en); end
    endtask

    task automatic test_dest0();
        pipe_wrt_en = 1'b1; pipe_wrt_dest = 5'd3; pipe_wrt_data = 32'h33;
        lu_valid = 1'b1; lu_dest = 5'd9; lu_data = 32'h99;
        tick();
        total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL d0_count got=%0d exp=1", fifo_count); end
        idle_inputs();
        pipe_wrt_en = 1'b1; pipe_wrt_dest = 5'd0; pipe_wrt_data = 32'hBAD;
        tick();
        total++; if (rg_wrt_en !== 1'b1 || rg_wrt_dest !== 5'd9 || rg_wrt_data !== 32'h99)
            begin bad++; $display("FAIL d0_pop got=%b/%0d/%h exp=1/9/99", rg_wrt_en, rg_wrt_dest, rg_wrt_data); end
        idle_inputs();
        lu_valid = 1'b1; lu_dest = 5'd0; lu_data = 32'h5555;
        total++; if (lu_ready !== 1'b1) begin bad++; $display("FAIL d0_ready got=%b exp=1", lu_ready); end
        tick();
        idle_inputs();
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL d0_drop_count got=%0d exp=0", fifo_count); end
        total++; if (rg_wrt_en !== 1'b0) begin bad++; $display("FAIL d0_no_write1 got=%b exp=0", rg_wrt_en); end
        tick();
        total++; if (rg_wrt_en !== 1'b0) begin bad++; $display("FAIL d0_no_write2 got=%b exp=0", rg_wrt_en); end
    endtask

    task automatic test_push_pop();
        lu_valid = 1'b1; lu_dest = 5'd11; lu_data = 32'h1;
        tick();
        lu_dest = 5'd12; lu_data = 32'h2;
        tick();
        total++; if (rg_wrt_en !== 1'b1 || rg_wrt_dest !== 5'd11 || rg_wrt_data !== 32'h1)
            begin bad++; $display("FAIL pp_first got=%b/%0d/%h exp=1/11/1", rg_wrt_en, rg_wrt_dest, rg_wrt_data); end
        total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL pp_count got=%0d exp=1", fifo_count); end
        idle_inputs();
        tick();
        total++; if (rg_wrt_en !== 1'b1 || rg_wrt_dest !== 5'd12 || rg_wrt_data !== 32'h2)
            begin bad++; $display("FAIL pp_second got=%b/%0d/%h exp=1/12/2", rg_wrt_en, rg_wrt_dest, rg_wrt_data); end
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL pp_empty got=%0d exp=0", fifo_count); end
    endtask

    task automatic test_pending_same();
        lu_issue = 1'b1; lu_issue_dest = 5'd4;
        tick();
        idle_inputs();
        total++; if (pending !== 32'h10) begin bad++; $display("FAIL ps_set got=%h exp=00000010", pending); end
        lu_valid = 1'b1; lu_dest = 5'd4; lu_data = 32'h44;
        tick();
        idle_inputs();
        lu_issue = 1'b1; lu_issue_dest = 5'd4;
        tick();
        idle_inputs();
        total++; if (rg_wrt_en !== 1'b1 || rg_wrt_dest !== 5'd4 || rg_wrt_data !== 32'h44)
            begin bad++; $display("FAIL ps_pop got=%b/%0d/%h exp=1/4/44", rg_wrt_en, rg_wrt_dest, rg_wrt_data); end
        total++; if (pending !== 32'h10) begin bad++; $display("FAIL ps_set_wins got=%h exp=00000010", pending); end
        tick();
        total++; if (pending !== 32'h10) begin bad++; $display("FAIL ps_hold got=%h exp=00000010", pending); end
    endtask

    task automatic test_reset_mid();
        lu_issue = 1'b1; lu_issue_dest = 5'd20;
        tick();
        lu_issue_dest = 5'd21;
        tick();
        lu_issue = 1'b0; lu_issue_dest = '0;
        for (int k = 0; k < 3; k++) begin
            pipe_wrt_en = 1'b1; pipe_wrt_dest = 5'd3; pipe_wrt_data = 32'h77;
            lu_valid = 1'b1; lu_dest = 5'(20 + k); lu_data = 32'hC0 + k;
            tick();
        end
        total++; if (fifo_count !== 3'd3) begin bad++; $display("FAIL rm_count_before got=%0d exp=3", fifo_count); end
        total++; if (pending !== 32'h0030_0010) begin bad++; $display("FAIL rm_pending_before got=%h exp=00300010", pending); end
        idle_inputs();
        rst = 1'b1;
        tick();
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL rm_count got=%0d exp=0", fifo_count); end
        total++; if (pending !== 32'h0) begin bad++; $display("FAIL rm_pending got=%h exp=0", pending); end
        total++; if (rg_wrt_en !== 1'b0) begin bad++; $display("FAIL rm_en got=%b exp=0", rg_wrt_en); end
        total++; if (lu_ready !== 1'b0) begin bad++; $display("FAIL rm_ready got=%b exp=0", lu_ready); end
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            total++; if (rg_wrt_en !== 1'b0) begin bad++; $display("FAIL rm_no_write[%0d] got=%b/%0d exp=0", k, rg_wrt_en, rg_wrt_dest); end
        end
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL rm_count_after got=%0d exp=0", fifo_count); end
    endtask

    initial begin
        test_reset();
        test_pipe_write();
        test_lu_latency();
        test_full();
        test_dest0();
        test_push_pop();
        test_pending_same();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_merge.md
# wb_merge

Writeback merge stage directly upstream of the register file write port. It combines two result sources onto the single write port and registers the chosen write toward the regfile: the in-order pipeline writeback and a long-latency unit (mul/div/load-miss) with valid/ready handshake. Long-latency results are buffered in a small FIFO. A per-register pending scoreboard is maintained for the decode stall logic. Outputs change on posedge, so they are stable when the regfile samples on negedge.

## Interface
- DATA_WIDTH, 32, bits per register value
- ADDRESS_WIDTH, 5, register index width
- NUM_REGS, 32, number of architectural registers; index 0 is hardwired zero
- FIFO_DEPTH, 4, long-latency result buffer entries; power of two, >= 2

- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- pipe_wrt_en  in  1  pipeline writeback valid; no backpressure
- pipe_wrt_dest  in  ADDRESS_WIDTH  pipeline destination register
- pipe_wrt_data  in  DATA_WIDTH  pipeline result
- lu_valid  in  1  long-latency result valid
- lu_ready  out  1  buffer can accept a result this cycle
- lu_dest  in  ADDRESS_WIDTH  long-latency destination register
- lu_data  in  DATA_WIDTH  long-latency result
- lu_issue  in  1  decode issued a long-latency op this cycle
- lu_issue_dest  in  ADDRESS_WIDTH  destination of the issued op
- rg_wrt_en  out  1  registered write enable to the regfile
- rg_wrt_dest  out  ADDRESS_WIDTH  registered write address
- rg_wrt_data  out  DATA_WIDTH  registered write data
- pending  out  NUM_REGS  scoreboard; bit i = result for register i outstanding
- fifo_count  out  clog2(FIFO_DEPTH)+1  current buffer occupancy

## Operation
- lu_ready = !rst && (fifo_count != FIFO_DEPTH). This is combinational from registered count only; a pop in the same cycle does not raise it.
- Accept: lu_valid && lu_ready.
  - lu_dest != 0: push {dest, data} at the tail.
  - lu_dest == 0: the result is consumed and dropped; nothing is pushed.
- Per-cycle selection for the output register, in strict priority:
  - 1. pipe_wrt_en && pipe_wrt_dest != 0: load the pipe write. The FIFO is not popped.
  - 2. Else, FIFO non-empty: pop the head and load it.
  - 3. Else: rg_wrt_en <= 0. rg_wrt_dest and rg_wrt_data hold their last values.
- Pipe writes to register 0 are dropped and never block a FIFO pop.
- No bypass: an entry accepted in cycle N is eligible for pop at cycle N+1 at the earliest.
- Push and pop in the same cycle are both performed; count is unchanged.
- Pointers wrap modulo FIFO_DEPTH. FIFO order is strictly preserved.
- The pipeline may starve the FIFO indefinitely. This is accepted: the pipeline only issues a long-latency-dependent op after pending clears.
- Scoreboard:
  - lu_issue && lu_issue_dest != 0 sets pending[lu_issue_dest].
  - A FIFO pop clears pending[popped dest].
  - Same register set and cleared in the same cycle: set wins.
  - pending[0] is constant 0.
  - Issue to an already-pending register is illegal; decode guarantees it never happens. Behaviour: the bit stays 1 and is cleared by the first completion.

## Timing
- Reset (rst=1 at a posedge), values after that edge:
  - rg_wrt_en=0, rg_wrt_dest=0, rg_wrt_data=0
  - pending=0, fifo_count=0, pointers=0
  - All inputs are ignored while rst=1; lu_ready=0 while rst=1.
- Reset mid-operation: buffered entries are discarded with no write emitted, pending clears, and no write appears in the cycle after reset.
- Pipe latency: pipe write sampled at edge N appears on rg_wrt_* after edge N, and is committed by the regfile at the following negedge.
- Long-latency latency: accepted at edge N, then with no pipe contention driven after edge N+1 (2 cycles).
- Full buffer: 4 accepted entries drop lu_ready the cycle after the 4th accept. It rises again the cycle after the first pop.
- Back-to-back: one write per cycle maximum; FIFO drains one entry per idle pipe cycle.

## Test plan
- Reset, then pipe write dest=5 data=0xDEADBEEF -> after the next edge rg_wrt_en=1, dest=5, data=0xDEADBEEF; then rg_wrt_en=0 if idle.
- lu_issue dest=7 at cycle 1, then lu_valid dest=7 data=0x1234 at cycle 4 with pipe idle:
  - pending[7]=1 from cycle 2.
  - Write of 0x1234 to register 7 appears after the cycle-5 edge.
  - pending[7]=0 at the same edge.
- Six consecutive lu_valid results while pipe_wrt_en=1 (dest=3) every cycle:
  - 4 accepted; lu_ready=0 thereafter.
  - Only dest=3 writes are output.
  - Drop pipe_wrt_en -> the 4 entries drain in order on 4 consecutive cycles, and lu_ready returns to 1 the cycle after the first pop.
- Pipe write to dest=0 with FIFO holding one entry (dest=9) -> the pipe write is dropped and the dest=9 entry is written that cycle. lu_valid dest=0 -> accepted, never written.
- lu_issue dest=4 in the same cycle a FIFO pop to dest=4 completes -> pending[4] remains 1.
- rst asserted with 3 entries buffered and pending bits set -> after the edge fifo_count=0, pending=0, rg_wrt_en=0, and no buffered write ever emerges.
